// File: rtl/vga_sync_rx_if.sv
// Bundles the sync inputs and recovered-timing outputs of the VGA sync receiver.
//   hSync, vSync : incoming syncs, active-low, driven by the source side
//   locked       : receiver is locked to the incoming timing
//   hCount       : recovered pixel column
//   vCount       : recovered line number
//   active       : locked and inside the active window
//   frame_start  : one-clk pulse at each frame boundary while locked
//   err_cnt      : saturating count of timing errors
interface vga_sync_rx_if;
  logic       hSync;
  logic       vSync;
  logic       locked;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       active;
  logic       frame_start;
  logic [7:0] err_cnt;

  // Source / monitor side.
  modport master (
    output hSync, vSync,
    input  locked, hCount, vCount, active, frame_start, err_cnt
  );

  // Receiver side.
  modport slave (
    input  hSync, vSync,
    output locked, hCount, vCount, active, frame_start, err_cnt
  );
endinterface

// File: rtl/vga_sync_rx.sv
// VGA sync receiver: synchronises hSync/vSync, measures line period and hSync
// width, recovers pixel column and line number, and locks to a stable stream.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : vga_sync_rx_if.slave (sync inputs, recovered timing outputs)
module vga_sync_rx #(
  parameter int unsigned H_TOTAL      = 800,
  parameter int unsigned H_SYNC       = 96,
  parameter int unsigned V_TOTAL      = 525,
  parameter int unsigned CLKS_PER_PIX = 4,
  parameter int unsigned H_ACT_START  = 144,
  parameter int unsigned H_ACT_END    = 784,
  parameter int unsigned V_ACT_START  = 35,
  parameter int unsigned V_ACT_END    = 515,
  parameter int unsigned LOCK_LINES   = 2
) (
  input logic          clk,
  input logic          rst_n,
  vga_sync_rx_if.slave bus
);

  localparam logic [12:0] LinePeriod = 13'(H_TOTAL * CLKS_PER_PIX - 1);
  localparam logic [12:0] SyncWidth  = 13'(H_SYNC * CLKS_PER_PIX);
  localparam logic [12:0] Timeout    = 13'(2 * H_TOTAL * CLKS_PER_PIX);
  localparam logic [9:0]  LastLine   = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HActStart  = 10'(H_ACT_START);
  localparam logic [9:0]  HActEnd    = 10'(H_ACT_END);
  localparam logic [9:0]  VActStart  = 10'(V_ACT_START);
  localparam logic [9:0]  VActEnd    = 10'(V_ACT_END);
  localparam int unsigned SubW       = (CLKS_PER_PIX > 1) ? $clog2(CLKS_PER_PIX) : 1;
  localparam logic [SubW-1:0] SubLast = SubW'(CLKS_PER_PIX - 1);
  localparam int unsigned GoodW      = (LOCK_LINES > 1) ? $clog2(LOCK_LINES) : 1;
  localparam logic [GoodW-1:0] GoodLast = GoodW'(LOCK_LINES - 1);

  typedef enum logic [1:0] {StSearch, StLineOk, StFrameWait, StLocked} state_e;

  state_e            state_q, state_d;
  logic              hs_meta_q, hs_sync_q, hs_prev_q;
  logic              vs_meta_q, vs_sync_q, vs_prev_q;
  logic [12:0]       clk_cnt_q, clk_cnt_d;
  logic [12:0]       low_w_q, low_w_d;
  logic [SubW-1:0]   sub_q, sub_d;
  logic [9:0]        hcount_q, hcount_d;
  logic [9:0]        vcount_q, vcount_d;
  logic              vpend_q, vpend_d;
  logic [GoodW-1:0]  good_q, good_d;
  logic [7:0]        err_q, err_d;
  logic              locked_q, active_q, fs_q, fs_d;
  logic              hs_fall, hs_rise, vs_fall;
  logic              line_bad, timeout, err_hit;

  assign hs_fall = hs_prev_q & ~hs_sync_q;
  assign hs_rise = ~hs_prev_q & hs_sync_q;
  assign vs_fall = vs_prev_q & ~vs_sync_q;

  // Line measurement and position counters.
  always_comb begin
    clk_cnt_d = clk_cnt_q;
    low_w_d   = low_w_q;
    sub_d     = sub_q;
    hcount_d  = hcount_q;
    vcount_d  = vcount_q;
    vpend_d   = vpend_q;

    if (hs_fall) begin
      clk_cnt_d = '0;
    end else if (clk_cnt_q != '1) begin
      clk_cnt_d = clk_cnt_q + 13'd1;
    end

    // Low width is cleared per line so a line without a rise never passes the check.
    if (hs_fall) begin
      low_w_d = '0;
    end else if (hs_rise) begin
      low_w_d = clk_cnt_q + 13'd1;
    end

    if (hs_fall) begin
      sub_d    = '0;
      hcount_d = '0;
    end else if (sub_q == SubLast) begin
      sub_d = '0;
      if (hcount_q != '1) hcount_d = hcount_q + 10'd1;
    end else begin
      sub_d = sub_q + 1'b1;
    end

    if (hs_fall) begin
      vpend_d = 1'b0;
      if (vpend_q || vs_fall) begin
        vcount_d = '0;
      end else if (vcount_q != '1) begin
        vcount_d = vcount_q + 10'd1;
      end
    end else if (vs_fall) begin
      vpend_d = 1'b1;
    end
  end

  // Lock FSM.
  always_comb begin
    line_bad = (clk_cnt_q != LinePeriod) || (low_w_q != SyncWidth);
    timeout  = (state_q != StSearch) && (clk_cnt_q == Timeout);
    state_d  = state_q;
    good_d   = good_q;
    err_hit  = 1'b0;
    fs_d     = 1'b0;

    unique case (state_q)
      StSearch: begin
        if (hs_fall) begin
          state_d = StLineOk;
          good_d  = '0;
        end
      end
      StLineOk: begin
        if (hs_fall) begin
          if (line_bad) begin
            err_hit = 1'b1;
          end else if (good_q == GoodLast) begin
            state_d = StFrameWait;
          end else begin
            good_d = good_q + 1'b1;
          end
        end
      end
      StFrameWait: begin
        if (hs_fall && line_bad) begin
          err_hit = 1'b1;
        end else if (vs_fall) begin
          state_d = StLocked;
        end
      end
      StLocked: begin
        if (hs_fall && line_bad) begin
          err_hit = 1'b1;
        end else if (vs_fall) begin
          if (vcount_q != LastLine) err_hit = 1'b1;
          else                      fs_d    = 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase

    if (timeout) err_hit = 1'b1;
    // Any error overrides a coincident vSync action.
    if (err_hit) begin
      state_d = StSearch;
      fs_d    = 1'b0;
    end

    err_d = (err_hit && (err_q != '1)) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StSearch;
      hs_meta_q <= 1'b1;
      hs_sync_q <= 1'b1;
      hs_prev_q <= 1'b1;
      vs_meta_q <= 1'b1;
      vs_sync_q <= 1'b1;
      vs_prev_q <= 1'b1;
      clk_cnt_q <= '0;
      low_w_q   <= '0;
      sub_q     <= '0;
      hcount_q  <= '0;
      vcount_q  <= '0;
      vpend_q   <= 1'b0;
      good_q    <= '0;
      err_q     <= '0;
      locked_q  <= 1'b0;
      active_q  <= 1'b0;
      fs_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      hs_meta_q <= bus.hSync;
      hs_sync_q <= hs_meta_q;
      hs_prev_q <= hs_sync_q;
      vs_meta_q <= bus.vSync;
      vs_sync_q <= vs_meta_q;
      vs_prev_q <= vs_sync_q;
      clk_cnt_q <= clk_cnt_d;
      low_w_q   <= low_w_d;
      sub_q     <= sub_d;
      hcount_q  <= hcount_d;
      vcount_q  <= vcount_d;
      vpend_q   <= vpend_d;
      good_q    <= good_d;
      err_q     <= err_d;
      locked_q  <= (state_d == StLocked);
      active_q  <= (state_d == StLocked) &&
                   (hcount_d >= HActStart) && (hcount_d < HActEnd) &&
                   (vcount_d >= VActStart) && (vcount_d < VActEnd);
      fs_q      <= fs_d;
    end
  end

  assign bus.locked      = locked_q;
  assign bus.hCount      = hcount_q;
  assign bus.vCount      = vcount_q;
  assign bus.active      = active_q;
  assign bus.frame_start = fs_q;
  assign bus.err_cnt     = err_q;

endmodule

// File: tb/tb_vga_sync_rx.sv
// Self-checking bench for vga_sync_rx using scaled-down timing so whole frames
// fit in a short run. A line-level reference model predicts lock state, error
// count and recovered position from the generated sync stream.
module tb_vga_sync_rx;
  localparam int HT = 40, HS = 6, VT = 12, CPP = 2;
  localparam int HAS = 10, HAE = 36, VAS = 2, VAE = 10, LL = 2;
  localparam int LINE = HT * CPP;
  localparam int SYNCW = HS * CPP;
  localparam int TMO = 2 * LINE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  vga_sync_rx_if bus ();

  vga_sync_rx #(
    .H_TOTAL(HT), .H_SYNC(HS), .V_TOTAL(VT), .CLKS_PER_PIX(CPP),
    .H_ACT_START(HAS), .H_ACT_END(HAE), .V_ACT_START(VAS), .V_ACT_END(VAE),
    .LOCK_LINES(LL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int fails = 0;

  // Reference model, advanced once per generated hSync falling edge.
  typedef enum {MSearch, MLineOk, MFrameWait, MLocked} mstate_e;
  mstate_e m_st = MSearch;
  int m_err = 0, m_good = 0, m_line = 0, m_prev_period = 0, m_prev_low = 0;

  task automatic bump_err();
    if (m_err < 255) m_err++;
    m_st = MSearch;
  endtask

  task automatic model_reset();
    m_st = MSearch; m_err = 0; m_good = 0; m_line = 0;
    m_prev_period = 0; m_prev_low = 0;
  endtask

  task automatic model_fall(input bit vs, output bit fs);
    bit good_line;
    good_line = (m_prev_period == LINE) && (m_prev_low == SYNCW);
    fs = 1'b0;
    case (m_st)
      MSearch: begin m_st = MLineOk; m_good = 0; end
      MLineOk: begin
        if (!good_line) bump_err();
        else begin m_good++; if (m_good == LL) m_st = MFrameWait; end
      end
      MFrameWait: begin
        if (!good_line) bump_err();
        else if (vs) m_st = MLocked;
      end
      MLocked: begin
        if (!good_line) bump_err();
        else if (vs) begin
          if (m_line != VT - 1) bump_err();
          else fs = 1'b1;
        end
      end
      default: m_st = MSearch;
    endcase
    m_line = vs ? 0 : ((m_line < 1023) ? m_line + 1 : 1023);
  endtask

  // One line: hSync low for 'low' clks, period 'period' clks, optional coincident
  // vSync fall. sj picks the mid-line sample offset (clks after the recovered
  // edge), negative for random.
  task automatic send_line(input int period, input int low, input bit vs, input int sj_in);
    bit fs, pre_lock, tmo, e_lock, e_act;
    int pre_err, sj, e_h, e_err;
    pre_lock = (m_st == MLocked);
    pre_err  = m_err;
    model_fall(vs, fs);
    tmo = (m_st != MSearch) && (period >= TMO + 2);
    sj  = (sj_in < 0) ? int'($urandom_range(period - 4, 1)) : sj_in;
    for (int k = 0; k < period; k++) begin
      @(posedge clk);
      #1;
      if (k == 0) begin bus.hSync = 1'b0; if (vs) bus.vSync = 1'b0; end
      if (k == low) begin bus.hSync = 1'b1; bus.vSync = 1'b1; end
      if (k == 2) begin
        vectors++;
        if (bus.locked !== pre_lock || bus.err_cnt !== 8'(pre_err)) begin
          fails++;
          $display("FAIL pre_edge: locked=%b err=%0d, want locked=%b err=%0d",
                   bus.locked, bus.err_cnt, pre_lock, pre_err);
        end
      end
      if (k == 3) begin
        vectors++;
        if (bus.locked !== (m_st == MLocked) || bus.err_cnt !== 8'(m_err) ||
            bus.hCount !== 10'd0 || bus.vCount !== 10'(m_line) || bus.frame_start !== fs) begin
          fails++;
          $display("FAIL at_edge: locked=%b err=%0d h=%0d v=%0d fs=%b, want %b %0d 0 %0d %b",
                   bus.locked, bus.err_cnt, bus.hCount, bus.vCount, bus.frame_start,
                   (m_st == MLocked), m_err, m_line, fs);
        end
      end
      if (k == 4 && fs) begin
        vectors++;
        if (bus.frame_start !== 1'b0) begin
          fails++;
          $display("FAIL fs_width: frame_start=%b, want 0", bus.frame_start);
        end
      end
      if (k == 3 + sj) begin
        e_h    = (sj / CPP > 1023) ? 1023 : sj / CPP;
        e_err  = m_err;
        e_lock = (m_st == MLocked);
        if (tmo && sj >= TMO + 1) begin
          e_err  = (m_err < 255) ? m_err + 1 : 255;
          e_lock = 1'b0;
        end
        e_act = e_lock && e_h >= HAS && e_h < HAE && m_line >= VAS && m_line < VAE;
        vectors++;
        if (bus.hCount !== 10'(e_h) || bus.vCount !== 10'(m_line) || bus.locked !== e_lock ||
            bus.active !== e_act || bus.err_cnt !== 8'(e_err)) begin
          fails++;
          $display("FAIL mid_line j=%0d: h=%0d v=%0d locked=%b act=%b err=%0d, want %0d %0d %b %b %0d",
                   sj, bus.hCount, bus.vCount, bus.locked, bus.active, bus.err_cnt,
                   e_h, m_line, e_lock, e_act, e_err);
        end
      end
    end
    if (tmo) bump_err();
    m_prev_period = period;
    m_prev_low    = low;
  endtask

  task automatic send_frame(input int nlines, input int bad_idx, input int bad_period,
                            input int dir_idx, input int dir_j);
    for (int i = 0; i < nlines; i++) begin
      send_line((i == bad_idx) ? bad_period : LINE, SYNCW, (i == 0),
                (i == dir_idx) ? dir_j : -1);
    end
  endtask

  task automatic lock_up();
    send_frame(VT, -1, 0, -1, 0);
    send_frame(VT, -1, 0, -1, 0);
  endtask

  task automatic test_reset();
    bus.hSync = 1'b1;
    bus.vSync = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (bus.locked !== 1'b0 || bus.hCount !== 10'd0 || bus.vCount !== 10'd0 ||
        bus.active !== 1'b0 || bus.frame_start !== 1'b0 || bus.err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_state: locked=%b h=%0d v=%0d act=%b fs=%b err=%0d, want all 0",
               bus.locked, bus.hCount, bus.vCount, bus.active, bus.frame_start, bus.err_cnt);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_lock();
    lock_up();
    send_frame(VT, -1, 0, -1, 0);
    vectors++;
    if (bus.locked !== 1'b1 || bus.err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL nominal_lock: locked=%b err=%0d, want 1 0", bus.locked, bus.err_cnt);
    end
  endtask

  task automatic test_active();
    send_frame(VT, -1, 0, VAS, HAS * CPP);
    send_frame(VT, -1, 0, VAS, HAE * CPP);
    send_frame(VT, -1, 0, VAE - 1, HAE * CPP - 1);
    send_frame(VT, -1, 0, VAE, HAS * CPP);
    send_frame(VT, -1, 0, VAS - 1, HAS * CPP);
  endtask

  task automatic test_stretch();
    send_frame(VT, int'($urandom_range(8, 3)), LINE + 4, -1, 0);
    lock_up();
    send_frame(VT, -1, 0, -1, 0);
  endtask

  // Bad last line, so the error lands on the same edge as the next vSync fall.
  task automatic test_coincident();
    send_frame(VT, VT - 1, LINE - 2, -1, 0);
    send_frame(VT, -1, 0, -1, 0);
    lock_up();
  endtask

  task automatic test_timeout();
    send_line(TMO + 50, SYNCW, 1'b0, TMO);
    lock_up();
    send_line(TMO + 50, SYNCW, 1'b0, TMO + 1);
    lock_up();
    send_line(2200, SYNCW, 1'b0, 2150);
    lock_up();
  endtask

  task automatic test_short_frame();
    send_frame(VT - 1, -1, 0, -1, 0);
    send_frame(VT, -1, 0, -1, 0);
    lock_up();
  endtask

  task automatic test_err_saturate();
    int p;
    for (int i = 0; i < 620; i++) begin
      p = int'($urandom_range(30, 8));
      send_line(p, int'($urandom_range(p - 3, 2)), 1'b0, -1);
    end
    vectors++;
    if (bus.err_cnt !== 8'd255) begin
      fails++;
      $display("FAIL err_saturate: err_cnt=%0d, want 255", bus.err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    lock_up();
    send_frame(5, -1, 0, -1, 0);
    #3;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.locked !== 1'b0 || bus.hCount !== 10'd0 || bus.vCount !== 10'd0 ||
        bus.active !== 1'b0 || bus.frame_start !== 1'b0 || bus.err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL reset_mid: locked=%b h=%0d v=%0d act=%b fs=%b err=%0d, want all 0",
               bus.locked, bus.hCount, bus.vCount, bus.active, bus.frame_start, bus.err_cnt);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    lock_up();
    send_frame(VT, -1, 0, -1, 0);
    vectors++;
    if (bus.locked !== 1'b1 || bus.err_cnt !== 8'd0) begin
      fails++;
      $display("FAIL relock_after_reset: locked=%b err=%0d, want 1 0", bus.locked, bus.err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_active();
    test_stretch();
    test_coincident();
    test_timeout();
    test_short_frame();
    test_err_saturate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
